set_assoc_icache: RTL and testbench
===================================

// Module: set_assoc_icache
// PURPOSE
// - Parametrised N-way set-associative, read-only instruction cache; next generation of the direct-mapped simple cache.
// - Sits between the RI5CY-style core fetch port and the AXI4 instruction memory (AXI VIP slave in system benches).
// - Refills whole lines by AXI4 INCR burst, round-robin replacement per set, flush, error return, hit/miss counters.
// PARAMETERS
// ADDR_WIDTH     32  byte-address width
// DATA_WIDTH     32  core word and AXI data width (power of 2, >= 32)
// WAYS           2   associativity (power of 2, >= 1)
// SETS           16  sets per way (power of 2)
// LINE_WORDS     4   words per line = AXI burst length (2..16)
// CNT_WIDTH      32  hit/miss counter width
// PORTS
// clk           in   1           clock; all logic on rising edge
// rst           in   1           reset, asynchronous, active-high
// instr_req     in   1           core fetch request
// instr_addr    in   ADDR_WIDTH  fetch byte address (word-aligned)
// instr_gnt     out  1           request accepted this cycle
// instr_rvalid  out  1           1-cycle pulse: instr_rdata/instr_err valid
// instr_rdata   out  DATA_WIDTH  fetched word
// instr_err     out  1           refill returned non-OKAY rresp
// flush         in   1           pulse: invalidate all lines
// flush_done    out  1           1-cycle pulse when invalidation performed
// m_axi_araddr  out  ADDR_WIDTH  line-aligned refill address
// m_axi_arlen   out  8           LINE_WORDS-1
// m_axi_arsize  out  3           log2(DATA_WIDTH/8)
// m_axi_arburst out  2           2'b01 INCR
// m_axi_arvalid out  1           AR valid
// m_axi_arready in   1           AR ready
// m_axi_rdata   in   DATA_WIDTH  R data
// m_axi_rresp   in   2           R response
// m_axi_rlast   in   1           R last beat
// m_axi_rvalid  in   1           R valid
// m_axi_rready  out  1           R ready
// hit_count     out  CNT_WIDTH   saturating hit counter
// miss_count    out  CNT_WIDTH   saturating miss counter
// BEHAVIOUR
// - Address split: word offset [log2(DW/8)+log2(LW)-1 : log2(DW/8)], index next log2(SETS) bits, tag the rest; byte bits ignored.
// - Reset: state IDLE; all valid bits, RR pointers, counters, beat counter 0; every output 0 except arlen/arsize/arburst constants.
// - FSM IDLE: instr_gnt = instr_req && !flush_pending (combinational); on grant latch addr -> LOOKUP.
// - LOOKUP: compare all ways; hit -> instr_rvalid=1, rdata from hit way, hit_count++, -> IDLE. gnt=0 here; hit latency 1 cycle after gnt.
// - Miss: miss_count++, victim = RR pointer of set -> REFILL_AR: arvalid=1, araddr line-aligned; hold until arready -> REFILL_R.
// - REFILL_R: rready=1; each rvalid beat writes victim data word[beat]; beat counter wraps at LINE_WORDS; sticky err if rresp!=2'b00.
// - On rlast beat: if no err, write tag, set valid, advance RR pointer (mod WAYS); if err, victim left invalid. -> RESPOND.
// - RESPOND: instr_rvalid=1, rdata=requested word (or 0), instr_err=sticky err; clear err -> IDLE.
// - rlast earlier/later than LINE_WORDS beats: refill completes on rlast only; counter wrap, no fault.
// - flush: latched into flush_pending any state; performed in IDLE before any grant: clear all valid bits, flush_done pulse.
//   Flush and req same IDLE cycle: flush wins, gnt=0. Flush during refill: line installed, then invalidated on IDLE return.
// - Counters saturate at all-ones; never wrap.
// - Async reset mid-refill: abort to IDLE; outstanding AXI burst abandoned (interconnect reset together).
// STRUCTURE
// - Shared package kuuga_cache_pkg: icache_state_t enum (IDLE, LOOKUP, REFILL_AR, REFILL_R, RESPOND), AXI_BURST_INCR, AXI_RESP_OKAY, clog2-derived width helpers.
// - Sub-module icache_way (one instance per way, generate loop): valid/tag/data arrays, 1 read port, line-word write, tag install, flush clear.
// - Top holds FSM, RR pointers, beat counter, error flag, counters, AXI drive.
// TESTING (defaults; memory word at byte 4i holds i)
// - Cold read 0x200 -> AR araddr 0x200 arlen 3 arsize 2 arburst 1; 4 beats; rvalid rdata 0x80, miss_count 1.
// - Then read 0x20C -> hit, no AR, rvalid 1 cycle after gnt, rdata 0x83, hit_count 1.
// - Read 0x000, 0x100, 0x200 (all set 0) then 0x000 -> three misses then 0x000 evicted (way 0), fourth read misses again.
// - R beat 2 with rresp 2'b10 on 0x040 -> rvalid with instr_err 1; reread 0x040 misses again (line not validated).
// - flush asserted during refill of 0x300 -> refill completes, response 0xC0, flush_done next IDLE, reread 0x300 misses.
// - rst asserted in REFILL_R -> all outputs 0 immediately; after release, prior hit 0x200 now misses.

Source files
------------

// File: rtl/set_assoc_icache_pkg.sv
// Shared definitions for the kuuga instruction cache family: FSM states,
// AXI encodings and width helpers.
package kuuga_cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        REFILL_AR,
        REFILL_R,
        RESPOND
    } icache_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // Index width that never collapses to zero bits for single-entry arrays.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/set_assoc_icache_way.sv
// One way of the instruction cache: valid/tag/data storage with a
// combinational lookup port and a line-word refill write port.
module icache_way
    import kuuga_cache_pkg::*;
#(
    parameter int unsigned TAG_W      = 24,
    parameter int unsigned IDX_W      = 4,
    parameter int unsigned WORD_W     = 2,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SETS       = 16,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IDX_W-1:0]      lookup_idx,
    input  logic [TAG_W-1:0]      lookup_tag,
    input  logic [WORD_W-1:0]     lookup_word,
    output logic                  hit,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic                  wr_en,
    input  logic [WORD_W-1:0]     wr_word,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  inv_en,
    input  logic                  install_en,
    input  logic [TAG_W-1:0]      install_tag,
    input  logic                  flush_clear
);

    logic [SETS-1:0]       valid;
    logic [TAG_W-1:0]      tag_mem  [SETS];
    logic [DATA_WIDTH-1:0] data_mem [SETS][LINE_WORDS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else if (flush_clear) begin
            valid <= '0;
        end else begin
            if (inv_en)
                valid[wr_idx] <= 1'b0;
            if (install_en)
                valid[wr_idx] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset; valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (install_en)
            tag_mem[wr_idx] <= install_tag;
        if (wr_en)
            data_mem[wr_idx][wr_word] <= wr_data;
    end

    always_comb begin
        hit     = valid[lookup_idx] && (tag_mem[lookup_idx] == lookup_tag);
        rd_data = data_mem[lookup_idx][lookup_word];
    end

endmodule

// File: rtl/set_assoc_icache.sv
// N-way set-associative read-only instruction cache with AXI4 INCR line
// refill, round-robin replacement, flush and saturating hit/miss counters.
module set_assoc_icache
    import kuuga_cache_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned WAYS       = 2,
    parameter int unsigned SETS       = 16,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instr_req,
    input  logic [ADDR_WIDTH-1:0] instr_addr,
    output logic                  instr_gnt,
    output logic                  instr_rvalid,
    output logic [DATA_WIDTH-1:0] instr_rdata,
    output logic                  instr_err,
    input  logic                  flush,
    output logic                  flush_done,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    output logic [CNT_WIDTH-1:0]  hit_count,
    output logic [CNT_WIDTH-1:0]  miss_count
);

    localparam int unsigned BYTE_W = $clog2(DATA_WIDTH / 8);
    localparam int unsigned WORD_W = idx_w(LINE_WORDS);
    localparam int unsigned IDX_W  = idx_w(SETS);
    localparam int unsigned TAG_W  = ADDR_WIDTH - IDX_W - WORD_W - BYTE_W;
    localparam int unsigned WAY_W  = idx_w(WAYS);

    icache_state_t         state;
    logic [TAG_W-1:0]      req_tag;
    logic [IDX_W-1:0]      req_idx;
    logic [WORD_W-1:0]     req_word;
    logic [WAY_W-1:0]      victim;
    logic [WAY_W-1:0]      rr [SETS];
    logic [WORD_W-1:0]     beat;
    logic                  err_flag;
    logic [DATA_WIDTH-1:0] resp_data;
    logic                  flush_pending;

    logic                  way_hit  [WAYS];
    logic [DATA_WIDTH-1:0] way_data [WAYS];
    logic                  any_hit;
    logic [DATA_WIDTH-1:0] hit_data;
    logic                  beat_fire;
    logic                  beat_bad;
    logic                  install_ok;
    logic [WAY_W-1:0]      rr_cur;
    logic [WAY_W-1:0]      rr_next;
    logic [WORD_W-1:0]     beat_next;
    logic                  unused_bits;

    assign unused_bits = ^instr_addr[BYTE_W-1:0];

    assign rr_cur     = rr[req_idx];
    assign rr_next    = (rr_cur == WAY_W'(WAYS - 1)) ? '0 : rr_cur + 1'b1;
    assign beat_next  = (beat == WORD_W'(LINE_WORDS - 1)) ? '0 : beat + 1'b1;
    assign beat_fire  = (state == REFILL_R) && m_axi_rvalid;
    assign beat_bad   = (m_axi_rresp != AXI_RESP_OKAY);
    assign install_ok = beat_fire && m_axi_rlast && !err_flag && !beat_bad;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        icache_way #(
            .TAG_W      (TAG_W),
            .IDX_W      (IDX_W),
            .WORD_W     (WORD_W),
            .DATA_WIDTH (DATA_WIDTH),
            .SETS       (SETS),
            .LINE_WORDS (LINE_WORDS)
        ) u_way (
            .clk         (clk),
            .rst         (rst),
            .lookup_idx  (req_idx),
            .lookup_tag  (req_tag),
            .lookup_word (req_word),
            .hit         (way_hit[w]),
            .rd_data     (way_data[w]),
            .wr_idx      (req_idx),
            .wr_en       (beat_fire && (victim == WAY_W'(w))),
            .wr_word     (beat),
            .wr_data     (m_axi_rdata),
            .inv_en      ((state == LOOKUP) && !any_hit && (rr_cur == WAY_W'(w))),
            .install_en  (install_ok && (victim == WAY_W'(w))),
            .install_tag (req_tag),
            .flush_clear ((state == IDLE) && flush_pending)
        );
    end

    always_comb begin
        any_hit  = 1'b0;
        hit_data = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (way_hit[w]) begin
                any_hit  = 1'b1;
                hit_data = hit_data | way_data[w];
            end
        end
    end

    // A raw flush in the same IDLE cycle as a request must already block the grant.
    assign instr_gnt     = (state == IDLE) && instr_req && !flush_pending && !flush;
    assign instr_rvalid  = ((state == LOOKUP) && any_hit) || (state == RESPOND);
    assign instr_err     = (state == RESPOND) && err_flag;
    assign m_axi_arvalid = (state == REFILL_AR);
    assign m_axi_rready  = (state == REFILL_R);
    assign m_axi_arlen   = 8'(LINE_WORDS - 1);
    assign m_axi_arsize  = 3'(BYTE_W);
    assign m_axi_arburst = AXI_BURST_INCR;

    always_comb begin
        instr_rdata = '0;
        if ((state == LOOKUP) && any_hit)
            instr_rdata = hit_data;
        else if ((state == RESPOND) && !err_flag)
            instr_rdata = resp_data;
    end

    always_comb begin
        m_axi_araddr = '0;
        if (state == REFILL_AR)
            m_axi_araddr = {req_tag, req_idx, (WORD_W + BYTE_W)'(0)};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            req_tag       <= '0;
            req_idx       <= '0;
            req_word      <= '0;
            victim        <= '0;
            beat          <= '0;
            err_flag      <= 1'b0;
            resp_data     <= '0;
            flush_pending <= 1'b0;
            flush_done    <= 1'b0;
            hit_count     <= '0;
            miss_count    <= '0;
            for (int unsigned s = 0; s < SETS; s++)
                rr[s] <= '0;
        end else begin
            flush_done <= 1'b0;
            if (flush)
                flush_pending <= 1'b1;
            case (state)
                IDLE: begin
                    if (flush_pending) begin
                        flush_pending <= flush;
                        flush_done    <= 1'b1;
                    end else if (instr_gnt) begin
                        req_tag  <= instr_addr[ADDR_WIDTH-1 -: TAG_W];
                        req_idx  <= instr_addr[BYTE_W + WORD_W +: IDX_W];
                        req_word <= instr_addr[BYTE_W +: WORD_W];
                        state    <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (any_hit) begin
                        if (hit_count != '1)
                            hit_count <= hit_count + 1'b1;
                        state <= IDLE;
                    end else begin
                        if (miss_count != '1)
                            miss_count <= miss_count + 1'b1;
                        victim    <= rr_cur;
                        beat      <= '0;
                        err_flag  <= 1'b0;
                        resp_data <= '0;
                        state     <= REFILL_AR;
                    end
                end
                REFILL_AR: begin
                    if (m_axi_arready)
                        state <= REFILL_R;
                end
                REFILL_R: begin
                    if (m_axi_rvalid) begin
                        beat <= beat_next;
                        if (beat == req_word)
                            resp_data <= m_axi_rdata;
                        if (beat_bad)
                            err_flag <= 1'b1;
                        if (m_axi_rlast) begin
                            if (install_ok)
                                rr[req_idx] <= rr_next;
                            state <= RESPOND;
                        end
                    end
                end
                RESPOND: begin
                    err_flag <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_set_assoc_icache.sv
// Directed bench for set_assoc_icache with a behavioural AXI4 read slave
// whose memory word at byte 4i holds i.
module tb_set_assoc_icache;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_req;
    logic [31:0] instr_addr;
    logic        instr_gnt;
    logic        instr_rvalid;
    logic [31:0] instr_rdata;
    logic        instr_err;
    logic        flush;
    logic        flush_done;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast;
    logic        m_axi_rvalid;
    logic        m_axi_rready;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int          n_pass  = 0;
    int          n_total = 0;
    int          ar_count = 0;
    logic [31:0] ar_addr  = '0;
    logic [7:0]  ar_len   = '0;
    logic [2:0]  ar_size  = '0;
    logic [1:0]  ar_burst = '0;
    logic [31:0] err_addr = 32'hFFFF_FFFF;

    always #5 clk = ~clk;

    set_assoc_icache dut (
        .clk           (clk),
        .rst           (rst),
        .instr_req     (instr_req),
        .instr_addr    (instr_addr),
        .instr_gnt     (instr_gnt),
        .instr_rvalid  (instr_rvalid),
        .instr_rdata   (instr_rdata),
        .instr_err     (instr_err),
        .flush         (flush),
        .flush_done    (flush_done),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arlen   (m_axi_arlen),
        .m_axi_arsize  (m_axi_arsize),
        .m_axi_arburst (m_axi_arburst),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rlast   (m_axi_rlast),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready),
        .hit_count     (hit_count),
        .miss_count    (miss_count)
    );

    // AXI read slave: 4-beat bursts, beat 2 returns SLVERR for err_addr.
    initial begin
        m_axi_arready = 1'b1;
        m_axi_rvalid  = 1'b0;
        m_axi_rdata   = '0;
        m_axi_rresp   = 2'b00;
        m_axi_rlast   = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && m_axi_arvalid) begin
                ar_addr  = m_axi_araddr;
                ar_len   = m_axi_arlen;
                ar_size  = m_axi_arsize;
                ar_burst = m_axi_arburst;
                ar_count = ar_count + 1;
                @(posedge clk);
                for (int b = 0; b < 4; b++) begin
                    @(negedge clk);
                    if (rst) break;
                    m_axi_rvalid = 1'b1;
                    m_axi_rdata  = (ar_addr >> 2) + 32'(b);
                    m_axi_rresp  = (ar_addr == err_addr && b == 2) ? 2'b10 : 2'b00;
                    m_axi_rlast  = (b == 3);
                    @(posedge clk);
                    #1;
                    m_axi_rvalid = 1'b0;
                    m_axi_rlast  = 1'b0;
                    m_axi_rresp  = 2'b00;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [31:0] a, input string tag);
        logic got;
        got = 1'b0;
        @(negedge clk);
        instr_req  = 1'b1;
        instr_addr = a;
        for (int k = 0; k < 50; k++) begin
            #1;
            if (instr_gnt) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_gnt"}, 64'(got), 64'd1);
        @(posedge clk);
        #1;
        instr_req = 1'b0;
    endtask

    task automatic wait_resp(input string tag, output logic [31:0] d, output logic e, output int lat);
        logic got;
        got = 1'b0;
        d   = '0;
        e   = 1'b0;
        lat = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            lat = lat + 1;
            if (instr_rvalid) begin
                d   = instr_rdata;
                e   = instr_err;
                got = 1'b1;
                break;
            end
        end
        chk({tag, "_rvalid"}, 64'(got), 64'd1);
    endtask

    // One fetch with its data/err, hit-or-miss latency and counter checks.
    task automatic fetch(input string tag, input logic [31:0] a, input logic [31:0] exp_d,
                         input logic exp_e, input logic is_hit, input int exp_hits,
                         input int exp_miss, input int exp_ars);
        logic [31:0] d;
        logic        e;
        int          lat;
        issue(a, tag);
        wait_resp(tag, d, e, lat);
        chk({tag, "_data"}, 64'(d), 64'(exp_d));
        chk({tag, "_err"}, 64'(e), 64'(exp_e));
        if (is_hit) chk({tag, "_lat"}, 64'(lat), 64'd1);
        else        chk({tag, "_misslat"}, 64'(lat > 2), 64'd1);
        @(negedge clk);
        chk({tag, "_hits"}, 64'(hit_count), 64'(exp_hits));
        chk({tag, "_miss"}, 64'(miss_count), 64'(exp_miss));
        chk({tag, "_ars"}, 64'(ar_count), 64'(exp_ars));
    endtask

    initial begin
        logic [31:0] d;
        logic        e;
        int          lat;
        logic        got;

        rst        = 1'b1;
        instr_req  = 1'b0;
        instr_addr = '0;
        flush      = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_gnt", 64'(instr_gnt), 64'd0);
        chk("rst_rvalid", 64'(instr_rvalid), 64'd0);
        chk("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
        chk("rst_rready", 64'(m_axi_rready), 64'd0);
        chk("rst_hits", 64'(hit_count), 64'd0);
        chk("rst_miss", 64'(miss_count), 64'd0);
        chk("rst_fdone", 64'(flush_done), 64'd0);
        chk("rst_arlen", 64'(m_axi_arlen), 64'd3);
        chk("rst_arsize", 64'(m_axi_arsize), 64'd2);
        chk("rst_arburst", 64'(m_axi_arburst), 64'd1);
        rst = 1'b0;

        // cold miss then hit in the same line
        fetch("cold200", 32'h200, 32'h80, 1'b0, 1'b0, 0, 1, 1);
        chk("ar_addr", 64'(ar_addr), 64'h200);
        chk("ar_len", 64'(ar_len), 64'd3);
        chk("ar_size", 64'(ar_size), 64'd2);
        chk("ar_burst", 64'(ar_burst), 64'd1);
        fetch("hit20c", 32'h20C, 32'h83, 1'b0, 1'b1, 1, 1, 1);

        // set 0 thrash: round-robin evicts every prior line
        fetch("s0_000", 32'h000, 32'h00, 1'b0, 1'b0, 1, 2, 2);
        fetch("s0_100", 32'h100, 32'h40, 1'b0, 1'b0, 1, 3, 3);
        fetch("s0_200", 32'h200, 32'h80, 1'b0, 1'b0, 1, 4, 4);
        fetch("s0_000b", 32'h000, 32'h00, 1'b0, 1'b0, 1, 5, 5);
        chk("evict_araddr", 64'(ar_addr), 64'h000);
        fetch("s0_204", 32'h204, 32'h81, 1'b0, 1'b1, 2, 5, 5);

        // error beat leaves the line invalid
        err_addr = 32'h040;
        fetch("err040", 32'h040, 32'h00, 1'b1, 1'b0, 2, 6, 6);
        err_addr = 32'hFFFF_FFFF;
        fetch("re040", 32'h040, 32'h10, 1'b0, 1'b0, 2, 7, 7);
        fetch("hit044", 32'h044, 32'h11, 1'b0, 1'b1, 3, 7, 7);

        // flush during refill of 0x300
        issue(32'h300, "fl300");
        got = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (m_axi_rready) begin
                got = 1'b1;
                break;
            end
        end
        chk("fl300_rready", 64'(got), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        wait_resp("fl300", d, e, lat);
        chk("fl300_data", 64'(d), 64'hC0);
        chk("fl300_err", 64'(e), 64'd0);
        got = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (flush_done) begin
                got = 1'b1;
                break;
            end
        end
        chk("fl300_done", 64'(got), 64'd1);
        fetch("re300", 32'h300, 32'hC0, 1'b0, 1'b0, 3, 9, 9);

        // flush and request in the same IDLE cycle
        @(negedge clk);
        flush      = 1'b1;
        instr_req  = 1'b1;
        instr_addr = 32'h300;
        #1;
        chk("flreq_gnt0", 64'(instr_gnt), 64'd0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flreq_gnt1", 64'(instr_gnt), 64'd0);
        @(negedge clk);
        #1;
        chk("flreq_done", 64'(flush_done), 64'd1);
        chk("flreq_gnt2", 64'(instr_gnt), 64'd1);
        instr_req = 1'b0;
        fetch("post_fl300", 32'h300, 32'hC0, 1'b0, 1'b0, 3, 10, 10);

        // reset in the middle of a refill
        fetch("pre_200", 32'h200, 32'h80, 1'b0, 1'b0, 3, 11, 11);
        fetch("pre_200h", 32'h200, 32'h80, 1'b0, 1'b1, 4, 11, 11);
        issue(32'h500, "rst500");
        got = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (m_axi_rready) begin
                got = 1'b1;
                break;
            end
        end
        chk("rst500_rready", 64'(got), 64'd1);
        rst = 1'b1;
        #1;
        chk("arst_rvalid", 64'(instr_rvalid), 64'd0);
        chk("arst_rdata", 64'(instr_rdata), 64'd0);
        chk("arst_err", 64'(instr_err), 64'd0);
        chk("arst_arvalid", 64'(m_axi_arvalid), 64'd0);
        chk("arst_araddr", 64'(m_axi_araddr), 64'd0);
        chk("arst_rready", 64'(m_axi_rready), 64'd0);
        chk("arst_hits", 64'(hit_count), 64'd0);
        chk("arst_miss", 64'(miss_count), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        fetch("post_rst200", 32'h200, 32'h80, 1'b0, 1'b0, 0, 1, 13);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
